// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and constants for the matmul job controller.
// Holds the controller state encoding, address-width helpers and the
// result FIFO entry layout. The optional watchdog is enabled by the
// MMCTRL_WATCHDOG_EN macro in matmul_job_controller.
package matmul_pkg;

    // Default job geometry and operand width.
    localparam int MM_M          = 3;
    localparam int MM_N          = 3;
    localparam int MM_P          = 3;
    localparam int MM_DATA_WIDTH = 8;
    localparam int MM_RES_W      = 2 * MM_DATA_WIDTH;

    // Address width for a memory of 'depth' entries (never below one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int MM_A_ADDR_W = addr_w(MM_M * MM_N);
    localparam int MM_B_ADDR_W = addr_w(MM_N * MM_P);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_RELEASE,
        ST_DRAIN
    } ctrl_state_t;

    // One buffered result: the C element plus an end-of-job tag.
    // The data field is sized from MM_DATA_WIDTH, so the controller's
    // DATA_WIDTH must stay equal to MM_DATA_WIDTH.
    typedef struct packed {
        logic                last;
        logic [MM_RES_W-1:0] data;
    } result_entry_t;

endpackage

// File: rtl/matmul_result_fifo.sv
// matmul_result_fifo: small show-ahead synchronous FIFO for results.
// The head entry is visible combinationally; it reads as zero while empty.
// A push and a pop in the same cycle are both honoured, even when full.
// flush discards all contents in one cycle.
module matmul_result_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr_reg[PTR_W-1:0]];

    // Storage write; contents need no reset because empty gates the head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_job_controller.sv
// matmul_job_controller: sequences one matrix-multiply core for a whole job.
// Loads A then B (row-major) from an operand stream into the core's memories,
// runs the start/done handshake and buffers results into an output stream
// with an end-of-job marker.
// Optional: define MMCTRL_WATCHDOG_EN to abort a stuck job after
// TIMEOUT_CYCLES cycles in RUN/RELEASE (sets timeout, flushes results).
module matmul_job_controller
    import matmul_pkg::*;
#(
    parameter int M              = MM_M,
    parameter int N              = MM_N,
    parameter int P              = MM_P,
    parameter int DATA_WIDTH     = MM_DATA_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int A_AW          = addr_w(M * N),
    localparam int B_AW          = addr_w(N * P)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [2*DATA_WIDTH-1:0]      out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overflow,
    output logic                         timeout,
    output logic                         mm_start,
    output logic [DATA_WIDTH-1:0]        mm_a_in,
    output logic [A_AW-1:0]              mm_a_addr,
    output logic                         mm_a_wen,
    output logic [DATA_WIDTH-1:0]        mm_b_in,
    output logic [B_AW-1:0]              mm_b_addr,
    output logic                         mm_b_wen,
    input  logic signed [2*DATA_WIDTH-1:0] mm_c_out,
    input  logic                         mm_c_valid,
    input  logic                         mm_done
);
    localparam int NUM_A     = M * N;
    localparam int NUM_OPS   = M * N + N * P;
    localparam int NUM_RES   = M * P;
    localparam int IDX_W     = addr_w(NUM_OPS);
    localparam int RES_IDX_W = addr_w(NUM_RES);

    ctrl_state_t           state_reg;
    ctrl_state_t           state_next;
    logic [IDX_W-1:0]      idx_reg;
    logic [RES_IDX_W-1:0]  res_in_reg;
    logic                  a_wen_reg;
    logic                  b_wen_reg;
    logic [A_AW-1:0]       a_addr_reg;
    logic [B_AW-1:0]       b_addr_reg;
    logic [DATA_WIDTH-1:0] wr_data_reg;
    logic                  last_popped_reg;
    logic                  overflow_reg;

    logic          in_hs;
    logic          job_begin;
    logic          is_a_elem;
    logic          is_final_elem;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_dropped;
    logic          wd_expired;
    result_entry_t push_entry;
    result_entry_t head_entry;

    assign in_hs         = in_valid && in_ready;
    assign job_begin     = in_hs && (state_reg == ST_IDLE);
    assign is_a_elem     = (idx_reg < IDX_W'(NUM_A));
    assign is_final_elem = (idx_reg == IDX_W'(NUM_OPS - 1));

`ifdef MMCTRL_WATCHDOG_EN
    localparam int WD_W = addr_w(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_reg;

    assign wd_expired = ((state_reg == ST_RUN) || (state_reg == ST_RELEASE)) &&
                        (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout    = timeout_reg;

    // Count cycles spent waiting on the core; restart outside RUN/RELEASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_reg <= '0;
        end else if ((state_reg == ST_RUN) || (state_reg == ST_RELEASE)) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end else begin
            wd_cnt_reg <= '0;
        end
    end

    // Sticky timeout flag, cleared when the next job starts loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_reg <= 1'b0;
        end else if (wd_expired) begin
            timeout_reg <= 1'b1;
        end else if (job_begin) begin
            timeout_reg <= 1'b0;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a watchdog expiry overrides every other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (in_hs) state_next = ST_LOAD;
            ST_LOAD:    if (in_hs && is_final_elem) state_next = ST_START;
            ST_START:   state_next = ST_RUN;
            ST_RUN:     if (mm_done) state_next = ST_RELEASE;
            ST_RELEASE: if (!mm_done) state_next = ST_DRAIN;
            ST_DRAIN:   if (last_popped_reg && fifo_empty) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (wd_expired) begin
            state_next = ST_IDLE;
        end
    end

    // State-decoded outputs; start is held for the whole of RUN so the core
    // sees it through done, and START leaves one cycle after the final write.
    always_comb begin
        in_ready = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
        mm_start = (state_reg == ST_RUN);
        busy     = (state_reg != ST_IDLE);
    end

    // Operand index and registered write port toward the core memories.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg     <= '0;
            a_wen_reg   <= 1'b0;
            b_wen_reg   <= 1'b0;
            a_addr_reg  <= '0;
            b_addr_reg  <= '0;
            wr_data_reg <= '0;
        end else begin
            a_wen_reg <= in_hs && is_a_elem;
            b_wen_reg <= in_hs && !is_a_elem;
            if (in_hs) begin
                wr_data_reg <= in_data;
                idx_reg     <= is_final_elem ? '0 : idx_reg + 1'b1;
                if (is_a_elem) begin
                    a_addr_reg <= A_AW'(idx_reg);
                end else begin
                    b_addr_reg <= B_AW'(idx_reg - IDX_W'(NUM_A));
                end
            end
        end
    end

    assign mm_a_in   = wr_data_reg;
    assign mm_b_in   = wr_data_reg;
    assign mm_a_addr = a_addr_reg;
    assign mm_b_addr = b_addr_reg;
    assign mm_a_wen  = a_wen_reg;
    assign mm_b_wen  = b_wen_reg;

    // Result tagging: the entry with index M*P-1 carries the end-of-job mark.
    assign push_entry.last = (res_in_reg == RES_IDX_W'(NUM_RES - 1));
    assign push_entry.data = mm_c_out;
    assign fifo_push       = mm_c_valid;
    assign fifo_pop        = out_valid && out_ready;
    assign fifo_dropped    = fifo_push && fifo_full && !fifo_pop;

    // Result index, end-of-job acceptance and sticky overflow tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_in_reg      <= '0;
            last_popped_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            if (job_begin) begin
                res_in_reg <= '0;
            end else if (mm_c_valid) begin
                res_in_reg <= res_in_reg + 1'b1;
            end

            if (job_begin) begin
                last_popped_reg <= 1'b0;
            end else if (fifo_pop && head_entry.last) begin
                last_popped_reg <= 1'b1;
            end

            if (fifo_dropped) begin
                overflow_reg <= 1'b1;
            end else if (job_begin) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    matmul_result_fifo #(
        .WIDTH ($bits(result_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (wd_expired),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head_entry.data;
    assign out_last  = out_valid && head_entry.last;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_matmul_job_controller.sv
// tb_matmul_job_controller: randomized self-checking bench for the job
// controller. A behavioural stand-in for the multiplier core sits on the
// core ports; expected C values come from plain matrix arithmetic on the
// operands the bench sends. Define MMCTRL_WATCHDOG_EN to add the watchdog test.
module tb_matmul_job_controller;
    localparam int M    = 3;
    localparam int N    = 3;
    localparam int P    = 3;
    localparam int DW   = 8;
    localparam int RW   = 16;
    localparam int NA   = M * N;
    localparam int NOPS = M * N + N * P;
    localparam int NRES = M * P;

    typedef logic signed [DW-1:0] op_arr_t [NOPS];
    typedef logic [RW-1:0]        res_arr_t [NRES];

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [RW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 overflow;
    logic                 timeout;
    logic                 mm_start;
    logic [DW-1:0]        mm_a_in;
    logic [3:0]           mm_a_addr;
    logic                 mm_a_wen;
    logic [DW-1:0]        mm_b_in;
    logic [3:0]           mm_b_addr;
    logic                 mm_b_wen;
    logic signed [RW-1:0] mm_c_out;
    logic                 mm_c_valid;
    logic                 mm_done;

    int checks = 0;
    int passed = 0;

    matmul_job_controller #(
        .M(M), .N(N), .P(P), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .overflow(overflow), .timeout(timeout),
        .mm_start(mm_start),
        .mm_a_in(mm_a_in), .mm_a_addr(mm_a_addr), .mm_a_wen(mm_a_wen),
        .mm_b_in(mm_b_in), .mm_b_addr(mm_b_addr), .mm_b_wen(mm_b_wen),
        .mm_c_out(mm_c_out), .mm_c_valid(mm_c_valid), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    // ---------------- multiplier core stand-in ----------------
    logic signed [DW-1:0] a_mem [16];
    logic signed [DW-1:0] b_mem [16];
    int mm_phase;
    int mm_cnt;
    bit mm_hang = 1'b0;

    function automatic logic [RW-1:0] core_elem(input int e);
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++) acc += int'(a_mem[(e / P) * N + k]) * int'(b_mem[k * P + (e % P)]);
        return acc[RW-1:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_phase <= 0; mm_cnt <= 0; mm_c_valid <= 1'b0; mm_c_out <= '0; mm_done <= 1'b0;
        end else begin
            mm_c_valid <= 1'b0;
            if (mm_a_wen) a_mem[mm_a_addr] <= mm_a_in;
            if (mm_b_wen) b_mem[mm_b_addr] <= mm_b_in;
            case (mm_phase)
                0: if (mm_start) begin mm_phase <= 1; mm_cnt <= 0; end
                1: begin
                    if (!mm_start) mm_phase <= 0;
                    else if (!mm_hang) begin
                        mm_c_out   <= core_elem(mm_cnt);
                        mm_c_valid <= 1'b1;
                        mm_cnt     <= mm_cnt + 1;
                        if (mm_cnt == NRES - 1) mm_phase <= 2;
                    end
                end
                default: begin
                    if (mm_start) mm_done <= 1'b1;
                    else begin mm_done <= 1'b0; mm_phase <= 0; end
                end
            endcase
        end
    end

    // ---------------- write-port monitor ----------------
    int          a_writes, b_writes, wen_overlap, start_with_write;
    logic [15:0] a_mask, b_mask;

    always @(negedge clk) begin
        if (!rst) begin
            if (mm_a_wen) begin a_writes++; a_mask[mm_a_addr] = 1'b1; end
            if (mm_b_wen) begin b_writes++; b_mask[mm_b_addr] = 1'b1; end
            if (mm_a_wen && mm_b_wen) wen_overlap++;
            if (mm_start && (mm_a_wen || mm_b_wen)) start_with_write++;
        end
    end

    task automatic clear_monitor();
        @(posedge clk);
        a_writes = 0; b_writes = 0; wen_overlap = 0; start_with_write = 0;
        a_mask = '0; b_mask = '0;
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_mm(input op_arr_t ops, output res_arr_t c);
        for (int r = 0; r < M; r++) begin
            for (int col = 0; col < P; col++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < N; k++) acc += int'(ops[r * N + k]) * int'(ops[NA + k * P + col]);
                c[r * P + col] = acc[RW-1:0];
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    logic [RW-1:0] got_data [$];
    bit            got_last [$];

    // mode 0: always valid, 1: every other cycle, 2: random
    task automatic load_job(input op_arr_t ops, input int mode, output bit ok);
        int k, cyc;
        bit v;
        k = 0; cyc = 0;
        while (k < NOPS && cyc < 400) begin
            @(negedge clk);
            cyc++;
            case (mode)
                0:       v = 1'b1;
                1:       v = cyc[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = v ? ops[k] : DW'($urandom);
            if (v && in_ready) k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        ok = (k == NOPS);
    endtask

    // mode 0: always ready, 1: at most three random stalls (keeps FIFO from overflowing)
    task automatic collect(input int mode, input int max_cyc);
        int stalls;
        bit r;
        stalls = 0;
        got_data.delete(); got_last.delete();
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            r = 1'b1;
            if (mode == 1 && stalls < 3 && $urandom_range(0, 3) == 0) begin r = 1'b0; stalls++; end
            out_ready = r;
            if (out_valid && r) begin got_data.push_back(out_data); got_last.push_back(out_last); end
            if (!busy && !out_valid) break;
        end
        out_ready = 1'b1;
    endtask

    task automatic make_identity(output op_arr_t ops);
        for (int i = 0; i < NA; i++) ops[i] = (i % (N + 1) == 0) ? DW'(1) : DW'(0);
        for (int i = 0; i < NA; i++) ops[NA + i] = DW'(i + 1);
    endtask

    task automatic make_random(output op_arr_t ops);
        for (int i = 0; i < NOPS; i++) ops[i] = DW'($urandom);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if ({in_ready, busy, out_valid, out_last, overflow, timeout, mm_start, mm_a_wen, mm_b_wen} !== 9'b1_0000_0000)
            $display("FAIL reset_flags: got %b want 100000000",
                     {in_ready, busy, out_valid, out_last, overflow, timeout, mm_start, mm_a_wen, mm_b_wen});
        else passed++;
        checks++;
        if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0000", out_data); else passed++;
        checks++;
        if ({mm_a_addr, mm_b_addr, mm_a_in, mm_b_in} !== '0)
            $display("FAIL reset_mm_port: got %h want 0", {mm_a_addr, mm_b_addr, mm_a_in, mm_b_in});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, out_valid, mm_start} !== 4'b1000)
            $display("FAIL post_reset_flags: got %b want 1000", {in_ready, busy, out_valid, mm_start});
        else passed++;
    endtask

    task automatic test_identity();
        op_arr_t ops;
        bit ok;
        make_identity(ops);
        clear_monitor();
        load_job(ops, 0, ok);
        collect(0, 200);
        checks++;
        if (got_data.size() !== NRES) $display("FAIL ident_count: got %0d want %0d", got_data.size(), NRES); else passed++;
        for (int i = 0; i < NRES; i++) begin
            checks++;
            if (i >= got_data.size() || got_data[i] !== RW'(i + 1) || got_last[i] !== (i == NRES - 1))
                $display("FAIL ident_c[%0d]: got %h last %b want %h last %b", i, got_data[i], got_last[i], RW'(i + 1), (i == NRES - 1));
            else passed++;
        end
        checks++;
        if ({busy, overflow, timeout} !== 3'b000) $display("FAIL ident_end_flags: got %b want 000", {busy, overflow, timeout}); else passed++;
    endtask

    task automatic test_negative();
        op_arr_t ops;
        bit ok;
        for (int i = 0; i < NA; i++) ops[i] = -8'sd1;
        for (int i = 0; i < NA; i++) ops[NA + i] = 8'sd2;
        load_job(ops, 2, ok);
        collect(0, 200);
        checks++;
        if (got_data.size() !== NRES) $display("FAIL neg_count: got %0d want %0d", got_data.size(), NRES); else passed++;
        for (int i = 0; i < NRES; i++) begin
            checks++;
            if (i >= got_data.size() || got_data[i] !== 16'hFFFA || got_last[i] !== (i == NRES - 1))
                $display("FAIL neg_c[%0d]: got %h last %b want fffa last %b", i, got_data[i], got_last[i], (i == NRES - 1));
            else passed++;
        end
    endtask

    task automatic test_toggle_valid();
        op_arr_t ops;
        bit ok;
        make_identity(ops);
        clear_monitor();
        load_job(ops, 1, ok);
        collect(0, 200);
        for (int i = 0; i < NRES; i++) begin
            checks++;
            if (i >= got_data.size() || got_data[i] !== RW'(i + 1))
                $display("FAIL toggle_c[%0d]: got %h want %h", i, got_data[i], RW'(i + 1));
            else passed++;
        end
        checks++;
        if (a_writes !== NA || b_writes !== NA) $display("FAIL toggle_write_count: got a=%0d b=%0d want 9/9", a_writes, b_writes); else passed++;
        checks++;
        if (a_mask !== 16'h01FF || b_mask !== 16'h01FF) $display("FAIL toggle_addr_set: got a=%h b=%h want 01ff/01ff", a_mask, b_mask); else passed++;
        checks++;
        if (wen_overlap !== 0) $display("FAIL toggle_wen_overlap: got %0d want 0", wen_overlap); else passed++;
        checks++;
        if (start_with_write !== 0) $display("FAIL toggle_start_early: got %0d want 0", start_with_write); else passed++;
    endtask

    task automatic test_back_to_back_random();
        op_arr_t  ops;
        res_arr_t exp;
        bit ok;
        for (int j = 0; j < 4; j++) begin
            make_random(ops);
            ref_mm(ops, exp);
            clear_monitor();
            load_job(ops, 2, ok);
            collect(1, 300);
            checks++;
            if (!ok || got_data.size() !== NRES) $display("FAIL rand%0d_count: got %0d load_ok %b want %0d", j, got_data.size(), ok, NRES); else passed++;
            for (int i = 0; i < NRES; i++) begin
                checks++;
                if (i >= got_data.size() || got_data[i] !== exp[i] || got_last[i] !== (i == NRES - 1))
                    $display("FAIL rand%0d_c[%0d]: got %h last %b want %h last %b", j, i, got_data[i], got_last[i], exp[i], (i == NRES - 1));
                else passed++;
            end
            checks++;
            if ({busy, overflow, start_with_write != 0} !== 3'b000)
                $display("FAIL rand%0d_end: got busy %b ovf %b early %0d want 0 0 0", j, busy, overflow, start_with_write);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        op_arr_t ops;
        bit ok;
        make_identity(ops);
        out_ready = 1'b0;
        load_job(ops, 0, ok);
        out_ready = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if ({overflow, out_valid, busy, out_last} !== 4'b1110)
            $display("FAIL ovf_flags: got ovf %b valid %b busy %b last %b want 1 1 1 0", overflow, out_valid, busy, out_last);
        else passed++;
        collect(0, 30);
        checks++;
        if (got_data.size() !== 4) $display("FAIL ovf_count: got %0d want 4", got_data.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_data.size() || got_data[i] !== RW'(i + 1) || got_last[i] !== 1'b0)
                $display("FAIL ovf_c[%0d]: got %h last %b want %h last 0", i, got_data[i], got_last[i], RW'(i + 1));
            else passed++;
        end
        checks++;
        if ({busy, in_ready} !== 2'b10) $display("FAIL ovf_stuck_drain: got busy %b in_ready %b want 1 0", busy, in_ready); else passed++;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, overflow, out_valid, in_ready} !== 4'b0001)
            $display("FAIL ovf_after_reset: got %b want 0001", {busy, overflow, out_valid, in_ready});
        else passed++;
    endtask

    task automatic test_mid_reset();
        op_arr_t  ops;
        res_arr_t exp;
        bit ok;
        int wait_cyc;
        make_random(ops);
        load_job(ops, 0, ok);
        wait_cyc = 0;
        while (!mm_start && wait_cyc < 50) begin @(negedge clk); wait_cyc++; end
        checks++;
        if (mm_start !== 1'b1) $display("FAIL midrst_reach_run: got mm_start %b want 1", mm_start); else passed++;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, out_valid, out_last, overflow, mm_start, mm_a_wen, mm_b_wen} !== 8'b1000_0000 || out_data !== '0)
            $display("FAIL midrst_outputs: got %b data %h want 10000000 data 0000",
                     {in_ready, busy, out_valid, out_last, overflow, mm_start, mm_a_wen, mm_b_wen}, out_data);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        make_random(ops);
        ref_mm(ops, exp);
        load_job(ops, 2, ok);
        collect(0, 200);
        for (int i = 0; i < NRES; i++) begin
            checks++;
            if (i >= got_data.size() || got_data[i] !== exp[i] || got_last[i] !== (i == NRES - 1))
                $display("FAIL midrst_c[%0d]: got %h last %b want %h last %b", i, got_data[i], got_last[i], exp[i], (i == NRES - 1));
            else passed++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL midrst_idle: got busy %b want 0", busy); else passed++;
    endtask

`ifdef MMCTRL_WATCHDOG_EN
    task automatic test_watchdog();
        op_arr_t ops;
        bit ok;
        int run_cyc;
        make_identity(ops);
        mm_hang = 1'b1;
        load_job(ops, 0, ok);
        run_cyc = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (timeout) break;
            if (mm_start) run_cyc++;
        end
        checks++;
        if (timeout !== 1'b1) $display("FAIL wd_timeout: got %b want 1", timeout); else passed++;
        checks++;
        if (run_cyc !== 64) $display("FAIL wd_run_cycles: got %0d want 64", run_cyc); else passed++;
        checks++;
        if ({mm_start, busy, out_valid, in_ready} !== 4'b0001)
            $display("FAIL wd_idle: got %b want 0001", {mm_start, busy, out_valid, in_ready});
        else passed++;
        mm_hang = 1'b0;
        load_job(ops, 0, ok);
        collect(0, 200);
        checks++;
        if (timeout !== 1'b0) $display("FAIL wd_clear: got %b want 0", timeout); else passed++;
        for (int i = 0; i < NRES; i++) begin
            checks++;
            if (i >= got_data.size() || got_data[i] !== RW'(i + 1))
                $display("FAIL wd_next_c[%0d]: got %h want %h", i, got_data[i], RW'(i + 1));
            else passed++;
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_identity();
        test_negative();
        test_toggle_valid();
        test_back_to_back_random();
        test_overflow();
        test_mid_reset();
`ifdef MMCTRL_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/matmul_job_controller.md
Name: matmul_job_controller

Overview:
- Sequences one `simple_generic_matrix_mult` instance for a complete job.
- Accepts a valid/ready operand stream (A then B, row-major) and writes it into the multiplier's A/B memories.
- Runs the start/done handshake and drains results into a buffered valid/ready result stream with an end-of-job marker.
- Sits between the system's streaming fabric and the multiplier core.

Parameters:
- M, 3, rows of A and C.
- N, 3, cols of A / rows of B (inner dimension).
- P, 3, cols of B and C.
- DATA_WIDTH, 8, signed operand width; result width is 2*DATA_WIDTH.
- FIFO_DEPTH, 4, result buffer entries (power of 2, >=2).
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with MMCTRL_WATCHDOG_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  DATA_WIDTH  signed operand
- in_valid  in  1  operand valid
- in_ready  out  1  operand accept
- out_data  out  2*DATA_WIDTH  C element, row-major
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_last  out  1  marks the M*P-th result of a job
- busy  out  1  high in any state other than IDLE
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- timeout  out  1  sticky watchdog flag (0 without macro)
- mm_start  out  1  to multiplier start
- mm_a_in, mm_a_addr, mm_a_wen  out  DATA_WIDTH, clog2(M*N), 1  A write port
- mm_b_in, mm_b_addr, mm_b_wen  out  DATA_WIDTH, clog2(N*P), 1  B write port
- mm_c_out  in  2*DATA_WIDTH  multiplier result
- mm_c_valid  in  1  result strobe
- mm_done  in  1  multiplier done

Behaviour:
- Reset: state=IDLE. All outputs 0 except in_ready=1. FIFO empty. Counters 0. overflow and timeout cleared.
- States and transitions:
  - IDLE: in_ready=1. On the first handshake go to LOAD and clear overflow.
  - LOAD: in_ready=1. Handshake index i runs 0..M*N+N*P-1.
  - START: entered when the last element has been written. Assert mm_start, go to RUN.
  - RUN: mm_start=1. When mm_done=1, go to RELEASE.
  - RELEASE: mm_start=0. Wait for mm_done=0.
  - DRAIN: wait until the FIFO is empty and out_last has been accepted, then return to IDLE.
- Operand routing:
  - A handshake on cycle t produces a registered write at t+1.
  - For i<M*N: mm_a_wen=1, mm_a_addr=i.
  - Otherwise: mm_b_wen=1, mm_b_addr=i-M*N.
  - At most one wen is high per cycle.
- Start timing: mm_start rises no earlier than the cycle after the final B write. It stays high until mm_done is seen, because the multiplier needs start held through done. Dropping it returns the core to idle.
- No new job is started while mm_done=1 (RELEASE guard).
- Result path:
  - Every mm_c_valid cycle pushes mm_c_out into the FIFO and increments res_in (0..M*P-1).
  - The output is FIFO head. out_valid=!empty. Pop on out_valid&&out_ready.
  - out_last=1 when the head entry is result index M*P-1. A tag bit is stored per entry.
- Full FIFO: push while full with no pop in the same cycle drops the value and sets overflow. A simultaneous push and pop at full is legal.
- Pipelining: no operands are accepted during START/RUN/RELEASE/DRAIN (in_ready=0).
- Mid-job reset: asynchronous return to reset values. The multiplier is reset by the same rst.
- Width: data is passed through unchanged. The multiplier truncates to 2*DATA_WIDTH; the controller does no arithmetic.

Optional Feature:
- MMCTRL_WATCHDOG_EN defined:
  - A counter runs in RUN and RELEASE.
  - On reaching TIMEOUT_CYCLES: deassert mm_start, set timeout, flush the FIFO, go to IDLE.
  - timeout clears on the next job's first handshake.
- Undefined: no counter; timeout tied 0.

Decomposition:
- Package matmul_pkg holds:
  - Controller state enum (IDLE, LOAD, START, RUN, RELEASE, DRAIN).
  - Address-width constants derived from M, N and P via $clog2.
  - Result-entry struct {last, data}.
- One sub-module: matmul_result_fifo (synchronous FIFO, depth FIFO_DEPTH, full/empty, push/pop, simultaneous push/pop at full).

Test Plan:
- Identity A, B=1..9, out_ready=1 → out_data 1..9 in order, out_last only with 9, busy back to 0, overflow=0.
- A all -1, B all 2 → nine results 16'hFFFA.
- in_valid toggling every other cycle during load → same results as the identity test. Exactly 9 A writes and 9 B writes, addresses 0..8. No wen overlap.
- out_ready=0 for the whole job, FIFO_DEPTH=4 → first 4 results retained, overflow=1. Releasing out_ready yields the 4 results; none has out_last set. Controller stays in DRAIN until a test-side reset.
- rst pulsed mid-RUN → all outputs at reset values, in_ready=1. A following full job completes correctly.
- With MMCTRL_WATCHDOG_EN and TIMEOUT_CYCLES=64, mm_done forced 0 → timeout=1 after 64 RUN cycles, mm_start=0, state IDLE.
